// File: rtl/lsu_pkg.sv
`default_nettype none
// lsu_pkg: shared size encodings, AXI response codes, FSM states and strobe helper (rev 1.0).
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_D,
    WR,
    WR_B,
    RESP
  } lsu_state_e;

  // Byte-lane enables for a 2^size access starting at byte lane off.
  function automatic logic [7:0] strb_of(input logic [1:0] size, input logic [2:0] off);
    logic [15:0] m;
    m = (16'd1 << (4'd1 << size)) - 16'd1;
    return m[7:0] << off;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// lsu_load_align: shifts the addressed bytes of a read beat down, truncates and extends (rev 1.0).
module lsu_load_align #(
  parameter int DATA_W = 64,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [OFF_W-1:0]  off,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] data
);
  import lsu_pkg::*;

  logic [DATA_W-1:0] shifted;
  logic              sign;
  logic              fill;
  int                nbits;

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    sign    = 1'b0;
    nbits   = DATA_W;
    case (size)
      SZ_B: begin sign = shifted[7];        nbits = 8;      end
      SZ_H: begin sign = shifted[15];       nbits = 16;     end
      SZ_W: begin sign = shifted[31];       nbits = 32;     end
      SZ_D: begin sign = shifted[DATA_W-1]; nbits = DATA_W; end
    endcase
    fill = sign & ~is_unsigned;
    data = shifted;
    // Full-width accesses have nbits == DATA_W, so they pass through untouched.
    for (int i = 0; i < DATA_W; i++) begin
      if (i >= nbits) data[i] = fill;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lsu_axi_gen2.sv
`default_nettype none
// lsu_axi_gen2: single-outstanding load/store unit bridging MEM-stage requests to AXI4-Lite (rev 2.0).
module lsu_axi_gen2 #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter int RD_W   = 5,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [RD_W-1:0]     req_rd,
  output logic                resp_valid,
  output logic                resp_wen,
  output logic [RD_W-1:0]     resp_rd,
  output logic [DATA_W-1:0]   resp_data,
  output logic                resp_err,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  input  logic [1:0]          m_axi_bresp,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp
);
  import lsu_pkg::*;

  localparam int         STRB_W = DATA_W/8;
  localparam logic [1:0] MAX_SZ = 2'(OFF_W);

  lsu_state_e        state;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [RD_W-1:0]   rd_q;
  logic [OFF_W-1:0]  off_q;
  logic              aw_done;
  logic              w_done;

  logic [OFF_W-1:0]  req_off;
  logic [ADDR_W-1:0] line_addr;
  logic              misaligned;
  logic [7:0]        strb8;
  logic              aw_hs;
  logic              w_hs;
  logic [DATA_W-1:0] load_data;

  assign req_off    = req_addr[OFF_W-1:0];
  assign line_addr  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign misaligned = (req_size > MAX_SZ) ||
                      ((req_addr[2:0] & ((3'd1 << req_size) - 3'd1)) != 3'd0);
  assign strb8      = strb_of(req_size, 3'(req_off));
  assign aw_hs      = m_axi_awvalid & m_axi_awready;
  assign w_hs       = m_axi_wvalid & m_axi_wready;
  assign req_ready  = (state == IDLE) && !rst;

  lsu_load_align #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_align (
    .rdata       (m_axi_rdata),
    .off         (off_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .data        (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      size_q        <= '0;
      uns_q         <= 1'b0;
      rd_q          <= '0;
      off_q         <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      resp_valid    <= 1'b0;
      resp_wen      <= 1'b0;
      resp_err      <= 1'b0;
      resp_rd       <= '0;
      resp_data     <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_rready  <= 1'b0;
    end else begin
      // The response is a single-cycle pulse; its fields return to 0 afterwards.
      resp_valid <= 1'b0;
      resp_wen   <= 1'b0;
      resp_err   <= 1'b0;
      resp_rd    <= '0;
      resp_data  <= '0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            size_q <= req_size;
            uns_q  <= req_unsigned;
            rd_q   <= req_rd;
            off_q  <= req_off;
            if (misaligned) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rd    <= req_rd;
            end else if (req_we) begin
              state         <= WR;
              aw_done       <= 1'b0;
              w_done        <= 1'b0;
              m_axi_awvalid <= 1'b1;
              m_axi_awaddr  <= line_addr;
              m_axi_wvalid  <= 1'b1;
              m_axi_wdata   <= req_wdata << {req_off, 3'b000};
              m_axi_wstrb   <= strb8[STRB_W-1:0];
            end else begin
              state         <= RD_A;
              m_axi_arvalid <= 1'b1;
              m_axi_araddr  <= line_addr;
            end
          end
        end
        RD_A: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_rready  <= 1'b1;
            state         <= RD_D;
          end
        end
        RD_D: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            resp_valid   <= 1'b1;
            resp_err     <= (m_axi_rresp != AXI_RESP_OKAY);
            resp_wen     <= (m_axi_rresp == AXI_RESP_OKAY);
            resp_rd      <= rd_q;
            resp_data    <= load_data;
            state        <= RESP;
          end
        end
        WR: begin
          if (aw_hs) begin
            m_axi_awvalid <= 1'b0;
            m_axi_awaddr  <= '0;
            aw_done       <= 1'b1;
          end
          if (w_hs) begin
            m_axi_wvalid <= 1'b0;
            m_axi_wdata  <= '0;
            m_axi_wstrb  <= '0;
            w_done       <= 1'b1;
          end
          // Handshakes landing in this very cycle count towards completion.
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            m_axi_bready <= 1'b1;
            state        <= WR_B;
          end
        end
        WR_B: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            resp_valid   <= 1'b1;
            resp_err     <= (m_axi_bresp != AXI_RESP_OKAY);
            resp_rd      <= rd_q;
            state        <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_axi_gen2.sv
`default_nettype none
// tb_lsu_axi_gen2: randomised AXI4-Lite slave plus transaction-level model of the load/store unit.
module tb_lsu_axi_gen2;
  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_ready, req_we, req_unsigned;
  logic [63:0] req_addr, req_wdata;
  logic [1:0] req_size;
  logic [4:0] req_rd;
  logic resp_valid, resp_wen, resp_err;
  logic [4:0] resp_rd;
  logic [63:0] resp_data;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [63:0] awaddr, wdata, araddr, rdata;
  logic [7:0] wstrb;
  logic [1:0] bresp, rresp;

  always #5 clk = ~clk;

  lsu_axi_gen2 #(.DATA_W(64), .ADDR_W(64), .RD_W(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_wen(resp_wen), .resp_rd(resp_rd), .resp_data(resp_data),
    .resp_err(resp_err),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata), .m_axi_rresp(rresp)
  );

  int total = 0;
  int bad = 0;
  bit abort = 0;
  int cyc = 0;

  // transaction model
  bit busy, t_load, t_mis, ar_seen, r_done, aw_seen, w_seen, b_done, resp_due;
  logic [63:0] t_line, t_wdata;
  logic [7:0] t_wstrb;
  logic [4:0] t_rd;
  int t_off, t_size;
  bit t_uns;
  bit e_wen, e_err;
  logic [63:0] e_data;
  int ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
  int lat_ar, lat_aw, lat_w, lat_r, lat_b;
  logic [63:0] r_data_val;
  logic [1:0] r_resp_val, b_resp_val;

  // pending request
  bit pend, p_we, p_uns;
  logic [63:0] p_addr, p_wdata;
  logic [1:0] p_size;
  logic [4:0] p_rd;
  int p_gap;

  // observations of DUT behaviour for hand-computed checks
  int obs_resp_cnt, obs_aw_hi, obs_w_hi, obs_accept, obs_resp_cyc, obs_awhs, obs_bready1, obs_bhs;
  bit obs_ar_any, obs_wen, obs_err;
  logic [63:0] obs_data, obs_araddr, obs_awaddr, obs_wdata;
  logic [7:0] obs_wstrb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] ext(input logic [63:0] d, input int off, input int size, input bit uns);
    int nb;
    logic [63:0] v, mask;
    nb = 8 << size;
    v = d >> (8 * off);
    if (nb == 64) return v;
    mask = (64'd1 << nb) - 64'd1;
    v = v & mask;
    if (!uns && (((v >> (nb - 1)) & 64'd1) == 64'd1)) v = v | ~mask;
    return v;
  endfunction

  task automatic model_reset();
    busy = 0; resp_due = 0; pend = 0;
    ar_seen = 0; r_done = 0; aw_seen = 0; w_seen = 0; b_done = 0;
  endtask

  task automatic obs_reset();
    obs_resp_cnt = 0; obs_aw_hi = 0; obs_w_hi = 0; obs_accept = -1; obs_resp_cyc = -1;
    obs_awhs = -1; obs_bready1 = -1; obs_bhs = -1; obs_ar_any = 0;
    obs_wen = 0; obs_err = 0; obs_data = '0; obs_araddr = '0; obs_awaddr = '0;
    obs_wdata = '0; obs_wstrb = '0;
  endtask

  task automatic drive_idle_inputs();
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_size = '0;
    req_unsigned = 0; req_rd = '0;
    awready = 0; wready = 0; arready = 0;
    bvalid = 0; bresp = '0; rvalid = 0; rdata = '0; rresp = '0;
  endtask

  // One clock: check outputs at the falling edge, then drive inputs for the next rising edge.
  task automatic step();
    bit x_ready, x_ar, x_r, x_aw, x_w, x_b, resp_next;
    @(negedge clk);
    cyc++;
    x_ready = !busy;
    x_ar = busy && t_load && !t_mis && !ar_seen;
    x_r  = busy && t_load && !t_mis && ar_seen && !r_done;
    x_aw = busy && !t_load && !t_mis && !aw_seen;
    x_w  = busy && !t_load && !t_mis && !w_seen;
    x_b  = busy && !t_load && !t_mis && aw_seen && w_seen && !b_done;

    chk("req_ready", req_ready, x_ready);
    chk("arvalid", arvalid, x_ar);
    chk("araddr", araddr, x_ar ? t_line : 64'd0);
    chk("rready", rready, x_r);
    chk("awvalid", awvalid, x_aw);
    chk("awaddr", awaddr, x_aw ? t_line : 64'd0);
    chk("wvalid", wvalid, x_w);
    chk("wdata", wdata, x_w ? t_wdata : 64'd0);
    chk("wstrb", wstrb, x_w ? t_wstrb : 8'd0);
    chk("bready", bready, x_b);
    chk("resp_valid", resp_valid, resp_due);
    if (resp_due && resp_valid) begin
      chk("resp_wen", resp_wen, e_wen);
      chk("resp_err", resp_err, e_err);
      chk("resp_rd", resp_rd, t_rd);
      chk("resp_data", resp_data, e_data);
    end

    if (resp_valid) begin
      obs_resp_cnt++; obs_resp_cyc = cyc;
      obs_wen = resp_wen; obs_err = resp_err; obs_data = resp_data;
    end
    if (arvalid) begin obs_ar_any = 1; obs_araddr = araddr; end
    if (awvalid) begin obs_aw_hi++; obs_awaddr = awaddr; end
    if (wvalid) begin obs_w_hi++; obs_wdata = wdata; obs_wstrb = wstrb; end
    if (bready && obs_bready1 < 0) obs_bready1 = cyc;

    resp_next = 0;
    arready = x_ar && (ar_cnt >= lat_ar);
    if (x_ar) begin if (arready) ar_seen = 1; else ar_cnt++; end
    awready = x_aw && (aw_cnt >= lat_aw);
    if (x_aw) begin if (awready) begin aw_seen = 1; obs_awhs = cyc; end else aw_cnt++; end
    wready = x_w && (w_cnt >= lat_w);
    if (x_w) begin if (wready) w_seen = 1; else w_cnt++; end

    if (x_r && r_cnt >= lat_r) begin
      rvalid = 1; rdata = r_data_val; rresp = r_resp_val; r_done = 1;
      e_data = ext(r_data_val, t_off, t_size, t_uns);
      e_err = (r_resp_val != 2'b00); e_wen = !e_err; resp_next = 1;
    end else begin
      if (x_r) r_cnt++;
      rvalid = 0; rdata = {$urandom, $urandom}; rresp = 2'($urandom_range(0, 3));
    end

    if (x_b && b_cnt >= lat_b) begin
      bvalid = 1; bresp = b_resp_val; b_done = 1; obs_bhs = cyc;
      e_data = '0; e_err = (b_resp_val != 2'b00); e_wen = 0; resp_next = 1;
    end else begin
      if (x_b) b_cnt++;
      bvalid = 0; bresp = 2'($urandom_range(0, 3));
    end

    if (x_ready && pend && p_gap == 0) begin
      req_valid = 1; req_we = p_we; req_addr = p_addr; req_wdata = p_wdata;
      req_size = p_size; req_unsigned = p_uns; req_rd = p_rd;
      busy = 1; pend = 0; obs_accept = cyc;
      t_load = !p_we; t_size = int'(p_size); t_uns = p_uns; t_rd = p_rd;
      t_off = int'(p_addr % 64'd8);
      t_mis = (p_addr % (64'd1 << p_size)) != 64'd0;
      t_line = p_addr - 64'(t_off);
      t_wdata = p_wdata << (8 * t_off);
      t_wstrb = 8'(((1 << (1 << t_size)) - 1) << t_off);
      ar_seen = 0; r_done = 0; aw_seen = 0; w_seen = 0; b_done = 0;
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      if (t_mis) begin e_err = 1; e_wen = 0; e_data = '0; resp_next = 1; end
    end else begin
      if (x_ready && pend) p_gap--;
      req_valid = 0; req_we = 1'($urandom); req_addr = {$urandom, $urandom};
      req_wdata = {$urandom, $urandom}; req_size = 2'($urandom);
      req_unsigned = 1'($urandom); req_rd = 5'($urandom);
    end

    if (resp_due) busy = 0;
    resp_due = resp_next;
  endtask

  task automatic run_txn(input bit we, input logic [63:0] addr, input logic [63:0] wd,
                         input logic [1:0] sz, input bit uns, input logic [4:0] rd, input int gap);
    p_we = we; p_addr = addr; p_wdata = wd; p_size = sz; p_uns = uns; p_rd = rd; p_gap = gap;
    pend = 1;
    obs_reset();
    for (int k = 0; k < 300; k++) begin
      step();
      if (!pend && !busy) break;
    end
    if (pend || busy) begin
      total++; bad++; abort = 1;
      $display("FAIL txn_timeout: got no response within 300 cycles, required one response");
    end
  endtask

  task automatic set_lat(input int ar, input int r, input int aw, input int w, input int b);
    lat_ar = ar; lat_r = r; lat_aw = aw; lat_w = w; lat_b = b;
  endtask

  initial begin
    rst = 1;
    drive_idle_inputs();
    model_reset();
    obs_reset();
    set_lat(0, 0, 0, 0, 0);
    r_data_val = '0; r_resp_val = 2'b00; b_resp_val = 2'b00;

    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_outputs", {awvalid, wvalid, bready, arvalid, rready, resp_wen, resp_err}, 0);
    chk("rst_buses", awaddr | wdata | araddr | resp_data | 64'(wstrb) | 64'(resp_rd), 0);
    rst = 0;

    // signed half load from the top of a doubleword
    r_data_val = 64'hFFEE_0000_0000_0000;
    run_txn(0, 64'h8000_0006, 64'd0, 2'd1, 0, 5'd7, 0);
    chk("ld_h_signed_data", obs_data, 64'hFFFF_FFFF_FFFF_FFEE);
    chk("ld_h_signed_wen", obs_wen, 1);
    chk("ld_h_araddr", obs_araddr, 64'h8000_0000);
    chk("ld_latency", 64'(obs_resp_cyc - obs_accept), 3);

    run_txn(0, 64'h8000_0006, 64'd0, 2'd1, 1, 5'd7, 1);
    chk("ld_h_unsigned_data", obs_data, 64'h0000_0000_0000_FFEE);

    // byte store lands on lane 3
    run_txn(1, 64'h1003, 64'hAB, 2'd0, 0, 5'd3, 0);
    chk("st_b_wstrb", obs_wstrb, 8'h08);
    chk("st_b_lane", (obs_wdata >> 24) & 64'hFF, 64'hAB);
    chk("st_b_awaddr", obs_awaddr, 64'h1000);
    chk("st_b_wen", obs_wen, 0);

    // slow address channel, immediate data channel
    set_lat(0, 0, 5, 0, 2);
    run_txn(1, 64'h2000, 64'h0123_4567_89AB_CDEF, 2'd3, 0, 5'd9, 0);
    chk("st_aw_held", obs_aw_hi, 6);
    chk("st_w_once", obs_w_hi, 1);
    chk("st_bready_after_aw", 64'(obs_bready1 - obs_awhs), 1);
    chk("st_resp_once", obs_resp_cnt, 1);
    chk("st_resp_after_b", 64'(obs_resp_cyc - obs_bhs), 1);

    // misaligned word load
    set_lat(0, 0, 0, 0, 0);
    run_txn(0, 64'h1002, 64'd0, 2'd2, 0, 5'd4, 0);
    chk("mis_no_ar", obs_ar_any, 0);
    chk("mis_err", obs_err, 1);
    chk("mis_wen", obs_wen, 0);
    chk("mis_latency", 64'(obs_resp_cyc - obs_accept), 1);

    // bus error on a dword load
    r_data_val = 64'h1122_3344_5566_7788; r_resp_val = 2'b10;
    set_lat(1, 3, 0, 0, 0);
    run_txn(0, 64'h3000, 64'd0, 2'd3, 0, 5'd5, 0);
    chk("slverr_err", obs_err, 1);
    chk("slverr_wen", obs_wen, 0);
    r_resp_val = 2'b00;

    // reset while waiting for read data
    set_lat(0, 1000, 0, 0, 0);
    p_we = 0; p_addr = 64'h4000; p_wdata = '0; p_size = 2'd3; p_uns = 0; p_rd = 5'd6; p_gap = 0;
    pend = 1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (busy && ar_seen && r_cnt >= 2) break;
    end
    chk("pre_rst_rready", rready, 1);
    rst = 1;
    #1;
    chk("arst_rready", rready, 0);
    chk("arst_req_ready", req_ready, 0);
    chk("arst_outputs", {awvalid, wvalid, bready, arvalid, resp_valid, resp_wen, resp_err}, 0);
    chk("arst_buses", awaddr | wdata | araddr | resp_data | 64'(wstrb) | 64'(resp_rd), 0);
    model_reset();
    drive_idle_inputs();
    @(negedge clk);
    rst = 0;
    obs_reset();
    repeat (4) step();
    chk("post_rst_no_resp", obs_resp_cnt, 0);
    set_lat(0, 0, 0, 0, 0);
    r_data_val = 64'h8000_0000_0000_0080;
    run_txn(0, 64'h4007, 64'd0, 2'd0, 0, 5'd1, 0);
    chk("post_rst_ld", obs_data, 64'hFFFF_FFFF_FFFF_FF80);

    // randomised traffic
    for (int n = 0; n < 300 && !abort; n++) begin
      logic [1:0] sz;
      logic [63:0] a;
      set_lat($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4),
              $urandom_range(0, 4), $urandom_range(0, 3));
      r_data_val = {$urandom, $urandom};
      r_resp_val = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      b_resp_val = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      sz = 2'($urandom_range(0, 3));
      a = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
      run_txn(1'($urandom), a, {$urandom, $urandom}, sz, 1'($urandom), 5'($urandom),
              $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
